// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the BIST checker
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam int          RESET_CYCLES  = 2;
  localparam int          SETTLE_CYCLES = 1;

  // Galois step for x^32+x^22+x^2+x+1, right-shifting form
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/design_bist_checker_if.sv
// rtl/design_bist_checker_if.sv - checker to DUT-pair bus (stimulus out, responses in)
interface design_bist_checker_if #(
  parameter int WIDTH = 32
);
  logic             dut_rst;
  logic [WIDTH-1:0] stim;
  logic [WIDTH-1:0] golden_out;
  logic [WIDTH-1:0] netlist_out;

  modport master (output dut_rst, output stim, input golden_out, input netlist_out);
  modport slave  (input dut_rst, input stim, output golden_out, output netlist_out);
endinterface

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - 32-bit Galois LFSR with seed load and advance enable
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  // An all-zero seed would lock the register at zero forever
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= SEED_EFF;
    end else if (load) begin
      lfsr <= SEED_EFF;
    end else if (advance) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  assign value = lfsr[WIDTH-1:0];

endmodule

// File: rtl/design_bist_checker.sv
// rtl/design_bist_checker.sv - golden vs netlist self-test sequencer and response checker
// Optional first-mismatch capture: BIST_FIRST_FAIL_CAPTURE_EN
module design_bist_checker
  import bist_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          NUM_VECTORS = 1000,
  parameter int          HOLD        = 2,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  design_bist_checker_if.master  dut,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            mismatch_cnt,
  output logic [15:0]            first_fail_idx,
  output logic [WIDTH-1:0]       first_fail_golden,
  output logic [WIDTH-1:0]       first_fail_netlist
);

  state_t           state;
  logic [15:0]      phase_cnt;
  logic [15:0]      vec_idx;
  logic             dut_rst_q;
  logic             stim_en;
  logic [WIDTH-1:0] lfsr_value;

  logic        reset_last, settle_last, hold_last, vec_last;
  logic        cmp_now, lfsr_load, lfsr_adv, mismatch;
  logic [15:0] mismatch_nxt;

  assign reset_last  = (phase_cnt == 16'(RESET_CYCLES - 1));
  assign settle_last = (phase_cnt == 16'(SETTLE_CYCLES - 1));
  assign hold_last   = (phase_cnt == 16'(HOLD - 1));
  assign vec_last    = (vec_idx == 16'(NUM_VECTORS));

  always_comb begin
    cmp_now   = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state)
      S_RESET: begin
        cmp_now   = reset_last;
        lfsr_load = reset_last;
      end
      S_SETTLE: lfsr_adv = settle_last;
      S_RUN: begin
        cmp_now  = hold_last;
        lfsr_adv = hold_last && !vec_last;
      end
      default: ;
    endcase
  end

  // Count is computed combinationally so a mismatch on the final compare is in pass before done rises
  assign mismatch     = cmp_now && (dut.golden_out != dut.netlist_out);
  assign mismatch_nxt = (mismatch && (mismatch_cnt != 16'hFFFF)) ? mismatch_cnt + 16'd1 : mismatch_cnt;

  bist_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  assign dut.dut_rst = dut_rst_q;
  assign dut.stim    = stim_en ? lfsr_value : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      phase_cnt    <= '0;
      vec_idx      <= '0;
      dut_rst_q    <= 1'b0;
      stim_en      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      mismatch_cnt <= mismatch_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_RESET;
            phase_cnt    <= '0;
            vec_idx      <= '0;
            dut_rst_q    <= 1'b1;
            stim_en      <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
          end
        end
        S_RESET: begin
          if (reset_last) begin
            state     <= S_SETTLE;
            phase_cnt <= '0;
            dut_rst_q <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        S_SETTLE: begin
          if (settle_last) begin
            state     <= S_RUN;
            phase_cnt <= '0;
            vec_idx   <= 16'd1;
            stim_en   <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        S_RUN: begin
          if (hold_last) begin
            phase_cnt <= '0;
            if (vec_last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mismatch_nxt == 16'd0);
            end else begin
              vec_idx <= vec_idx + 16'd1;
            end
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BIST_FIRST_FAIL_CAPTURE_EN
  logic [15:0] cmp_idx;
  logic        start_accept;

  assign cmp_idx      = (state == S_RESET) ? 16'd0 : vec_idx;
  assign start_accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_fail_idx     <= '0;
      first_fail_golden  <= '0;
      first_fail_netlist <= '0;
    end else if (start_accept) begin
      first_fail_idx     <= '0;
      first_fail_golden  <= '0;
      first_fail_netlist <= '0;
    end else if (mismatch && (mismatch_cnt == 16'd0)) begin
      first_fail_idx     <= cmp_idx;
      first_fail_golden  <= dut.golden_out;
      first_fail_netlist <= dut.netlist_out;
    end
  end
`else
  assign first_fail_idx     = '0;
  assign first_fail_golden  = '0;
  assign first_fail_netlist = '0;
`endif

endmodule

// File: tb/tb_design_bist_checker.sv
// tb/tb_design_bist_checker.sv - scoreboard bench for design_bist_checker
`timescale 1ns/1ps
module tb_design_bist_checker;

  localparam int          W       = 32;
  localparam int          NV      = 1000;
  localparam int          HD      = 2;
  localparam logic [31:0] SD      = 32'h0;
  localparam int          SNV     = 65535;
  localparam int          SHD     = 1;
  localparam logic [31:0] RST_VAL = 32'h0000_1240;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  function automatic logic [31:0] gold_f(input logic [31:0] v);
    return (v * 32'h9E37_79B1) ^ {v[15:0], v[31:16]};
  endfunction

  // Main instance: netlist model switchable per run
  logic        rst, start, busy, done, pass;
  logic [15:0] mismatch_cnt, ff_idx;
  logic [31:0] ff_g, ff_n;
  int          mode = 0;
  logic [31:0] fault_vec = '0;

  design_bist_checker_if #(.WIDTH(W)) bus ();

  assign bus.golden_out = bus.dut_rst ? RST_VAL : gold_f(bus.stim);
  always_comb begin
    case (mode)
      1:       bus.netlist_out = bus.golden_out | 32'h20;
      2:       bus.netlist_out = (!bus.dut_rst && bus.stim == fault_vec) ? bus.golden_out ^ 32'h1 : bus.golden_out;
      3:       bus.netlist_out = (bus.stim[3:0] == 4'hA) ? bus.golden_out ^ 32'h8000_0000 : bus.golden_out;
      default: bus.netlist_out = bus.golden_out;
    endcase
  end

  design_bist_checker #(.WIDTH(W), .NUM_VECTORS(NV), .HOLD(HD), .SEED(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .dut(bus),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(ff_idx), .first_fail_golden(ff_g), .first_fail_netlist(ff_n)
  );

  // Saturation instance: netlist always disagrees
  logic        rst_s, start_s, busy_s, done_s, pass_s;
  logic [15:0] mismatch_cnt_s, ff_idx_s;
  logic [31:0] ff_g_s, ff_n_s;

  design_bist_checker_if #(.WIDTH(W)) bus_s ();
  assign bus_s.golden_out  = bus_s.dut_rst ? RST_VAL : gold_f(bus_s.stim);
  assign bus_s.netlist_out = ~bus_s.golden_out;

  design_bist_checker #(.WIDTH(W), .NUM_VECTORS(SNV), .HOLD(SHD), .SEED(32'h1)) dut_s (
    .clk(clk), .rst(rst_s), .start(start_s), .dut(bus_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .mismatch_cnt(mismatch_cnt_s),
    .first_fail_idx(ff_idx_s), .first_fail_golden(ff_g_s), .first_fail_netlist(ff_n_s)
  );

  // Reference model: vector list from the polynomial rule, expected run summary
  logic [31:0] vecs [0:NV];

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  function automatic logic [31:0] net_ref(input int m, input int k, input int fk,
                                          input logic [31:0] v, input logic [31:0] g);
    case (m)
      1:       return g | 32'h20;
      2:       return (k == fk && k > 0) ? g ^ 32'h1 : g;
      3:       return (v[3:0] == 4'hA) ? g ^ 32'h8000_0000 : g;
      default: return g;
    endcase
  endfunction

  typedef struct {
    int unsigned t0;
    int unsigned cycles;
    logic [15:0] cnt;
    logic        pass;
    logic [15:0] ff_idx;
    logic [31:0] ff_g;
    logic [31:0] ff_n;
    logic [31:0] first_stim;
    logic [31:0] last_stim;
  } exp_t;

  exp_t sb[$];

  task automatic issue_run(input int m, input int fk, input bit poke_busy);
    exp_t        e;
    logic [31:0] v, g, n;
    bit          found;
    int          w;
    e.cnt = 0; e.ff_idx = 0; e.ff_g = 0; e.ff_n = 0;
    found = 0;
    for (int k = 0; k <= NV; k++) begin
      v = (k == 0) ? 32'h0 : vecs[k];
      g = (k == 0) ? RST_VAL : gold_f(v);
      n = net_ref(m, k, fk, v, g);
      if (g != n) begin
        if (!found) begin
          found = 1;
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
          e.ff_idx = 16'(k); e.ff_g = g; e.ff_n = n;
`endif
        end
        if (e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
      end
    end
    e.pass       = (e.cnt == 0);
    e.cycles     = 3 + NV * HD;
    e.first_stim = vecs[1];
    e.last_stim  = vecs[NV];
    @(negedge clk);
    mode      = m;
    fault_vec = (fk > 0) ? vecs[fk] : 32'h0;
    start     = 1'b1;
    e.t0      = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (poke_busy) begin
      repeat ($urandom_range(1, NV * HD)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    w = 0;
    while (sb.size() != 0 && w < int'(e.cycles) + 20) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      fail_now("run_timeout");
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_dut_rst"}, bus.dut_rst, 1'b0);
    check({tag, "_stim"}, bus.stim, 32'h0);
    check({tag, "_cnt"}, mismatch_cnt, 16'h0);
    check({tag, "_ff"}, {ff_idx, ff_g, ff_n}, 80'h0);
  endtask

  // Monitor: pops one expected record per done rising edge
  initial begin
    bit   busy_prev = 0, done_prev = 0, seen_first = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (busy && !busy_prev) seen_first = 0;
        if (sb.size() > 0 && cyc == sb[0].t0)
          check("start_to_busy_dut_rst", {busy, bus.dut_rst}, 2'b11);
        if (busy && !seen_first && bus.stim != 0 && sb.size() > 0) begin
          seen_first = 1;
          check("first_stim", bus.stim, sb[0].first_stim);
        end
        if (done && !done_prev) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            e = sb.pop_front();
            check("run_cycles", cyc - e.t0, e.cycles);
            check("mismatch_cnt", mismatch_cnt, e.cnt);
            check("pass", pass, e.pass);
            check("first_fail_idx", ff_idx, e.ff_idx);
            check("first_fail_golden", ff_g, e.ff_g);
            check("first_fail_netlist", ff_n, e.ff_n);
            check("stim_held_last", bus.stim, e.last_stim);
          end
        end
      end
      busy_prev = busy;
      done_prev = done;
    end
  end

  initial begin
    logic [31:0] x;
    int unsigned t0s;
    int          w;
    x = (SD == 32'h0) ? 32'h1 : SD;
    vecs[0] = 32'h0;
    for (int k = 1; k <= NV; k++) begin
      x = lfsr_next(x);
      vecs[k] = x;
    end
    rst = 1'b0; rst_s = 1'b0; start = 1'b0; start_s = 1'b0;
    #1;
    check_reset_vals("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1; rst_s = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    fork
      begin
        @(negedge clk);
        start_s = 1'b1;
        t0s     = cyc + 1;
        @(negedge clk);
        start_s = 1'b0;
        w = 0;
        while (!done_s && w < SNV * SHD + 100) begin
          @(negedge clk);
          w++;
        end
        if (!done_s) begin
          fail_now("sat_timeout");
        end else begin
          check("sat_cycles", cyc - t0s, 3 + SNV * SHD);
          check("sat_cnt", mismatch_cnt_s, 16'hFFFF);
          check("sat_pass", pass_s, 1'b0);
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
          check("sat_ff", {ff_idx_s, ff_g_s, ff_n_s}, {16'h0, RST_VAL, ~RST_VAL});
`else
          check("sat_ff", {ff_idx_s, ff_g_s, ff_n_s}, 80'h0);
`endif
        end
      end
      begin
        issue_run(0, 0, 0);
        issue_run(1, 0, 1);
        issue_run(2, 7, 0);
        issue_run(2, NV, 0);
        issue_run(3, 0, 1);
        for (int i = 0; i < 2; i++)
          issue_run($urandom_range(0, 3), $urandom_range(1, NV), 1'($urandom_range(0, 1)));

        // Abort a run at vector 300 with the asynchronous reset
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (bus.stim != vecs[300] && w < 5000) begin
          @(negedge clk);
          w++;
        end
        if (bus.stim != vecs[300]) fail_now("abort_reach_300");
        rst = 1'b0;
        #1;
        check_reset_vals("abort");
        @(posedge clk);
        #1;
        check_reset_vals("abort_edge");
        @(negedge clk);
        rst = 1'b1;
        issue_run(0, 0, 0);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/design_bist_checker.md
# design_bist_checker

Synthesizable self-test engine that drives pseudo-random stimulus into two copies of a design, the golden RTL and the post-route netlist, and checks their responses in hardware. It is the on-chip counterpart of the post-route simulation bench. It sequences a reset phase followed by NUM_VECTORS random vectors, compares the two 32-bit responses per vector, counts mismatches and reports pass/fail. It sits at the top of a silicon/FPGA test wrapper, between a control register block and the two DUT instances.

## Interface
- WIDTH, 32, stimulus and response width
- NUM_VECTORS, 1000, random vectors applied after reset phase (1..65535)
- HOLD, 2, cycles each vector is held before compare (>=1)
- SEED, 32'h0000_0001, LFSR seed; 0 is replaced by 1

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- dut_rst  out  1  active-high reset driven to both DUTs
- stim  out  WIDTH  stimulus to both DUT `in` ports
- golden_out  in  WIDTH  golden DUT response
- netlist_out  in  WIDTH  netlist DUT response
- busy  out  1  high in RESET, SETTLE, RUN
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 iff mismatch_cnt==0
- mismatch_cnt  out  16  saturating mismatch count
- first_fail_idx  out  16  compare index of first mismatch (0 = reset compare)
- first_fail_golden  out  WIDTH  golden value at first mismatch
- first_fail_netlist  out  WIDTH  netlist value at first mismatch

## Operation
- FSM states: IDLE, RESET, SETTLE, RUN, DONE.
- IDLE: stim=0, dut_rst=0. start -> RESET.
- RESET (2 cycles): dut_rst=1, stim=0. On the 2nd cycle, perform compare index 0. Then -> SETTLE.
- SETTLE (1 cycle): dut_rst=0, stim=0. LFSR reloads SEED. Then -> RUN.
- RUN: for each vector k=1..NUM_VECTORS:
  - On the first cycle, advance the LFSR and present it on stim.
  - Hold stim for HOLD cycles.
  - On the last hold cycle, compare golden_out vs netlist_out (index k).
  - After compare NUM_VECTORS -> DONE.
- DONE: stim held at last vector, dut_rst=0, pass valid. start -> RESET. A new run clears counters and capture at the RESET entry edge.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Shift right; when the LSB is 1, XOR the shifted value with 32'h8020_0003. stim = LFSR[WIDTH-1:0].
- Compare is exact equality. On mismatch, mismatch_cnt increments and saturates at 16'hFFFF.
- start while busy is ignored.

## Timing
- Reset values: dut_rst=0, stim=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_*=0; state IDLE.
- start sampled at edge T: busy=1 and dut_rst=1 from T+1.
- Total run = 2 + 1 + NUM_VECTORS*HOLD cycles from start to done=1.
- Compare samples the responses registered at the compare edge; mismatch_cnt updates one cycle later.
- Mismatch on the final compare and the DONE transition occur on the same edge: the count must include it before done rises.
- rst assertion mid-run: immediate return to IDLE, all outputs to reset values, and dut_rst deasserted.

## Configuration
- BIST_FIRST_FAIL_CAPTURE_EN defined: first_fail_idx/golden/netlist are captured on the first mismatch only and held until the next start.
- Undefined: capture registers are omitted and the three first_fail outputs are tied to 0. Counting and pass/fail are unchanged.

## Structure
- Package bist_pkg holds:
  - the state enum
  - LFSR polynomial constant 32'h8020_0003
  - RESET_CYCLES=2 and SETTLE_CYCLES=1
- Sub-module bist_lfsr: seed load, advance enable, WIDTH-bit output.
- Top contains the FSM, hold counter, vector counter, comparator, mismatch counter and optional capture.

## Test plan
- Identical DUT models, NUM_VECTORS=1000, HOLD=2 -> done at cycle 2003 after start, pass=1, mismatch_cnt=0.
- Netlist model with bit 5 stuck-at-1 -> pass=0, mismatch_cnt equals the count of vectors with bit5=0 (model-predicted); first_fail_idx=0 when the reset output has bit5=0.
- Netlist XOR 1 only on vector 7, NUM_VECTORS=10 -> mismatch_cnt=1, first_fail_idx=7; with the macro defined, first_fail_netlist = first_fail_golden ^ 1.
- Always-mismatching model, NUM_VECTORS=65535, HOLD=1 -> mismatch_cnt stays at 16'hFFFF after saturation.
- rst low at vector 300 -> outputs return to reset values next edge; a following start gives a clean pass run.
- SEED=0, first stim equals the vector produced from seed 1. start pulse while busy -> no effect on cycle count.
